// File: rtl/tx_rt_timer_scanner.sv
// Per-flow retransmit timer scanner.
// Holds one armed timer and one timeout_pending flag per flow, visits one flow
// per cycle in round-robin order, and raises a val/rdy timeout request when an
// armed timer has run for RT_TIMEOUT cycles or more. The scan pauses while a
// request waits for the consumer, so no expiry is ever dropped.
module tx_rt_timer_scanner #(
  parameter int NUM_FLOWS   = 8,
  parameter int FLOW_ID_W   = 3,
  parameter int TIMESTAMP_W = 16,
  parameter int RT_TIMEOUT  = 1000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   set_timer_val,
  input  logic [FLOW_ID_W-1:0]   set_timer_flowid,
  input  logic                   set_timer_arm,
  input  logic                   timeout_clr_val,
  input  logic [FLOW_ID_W-1:0]   timeout_clr_flowid,
  output logic                   timeout_req_val,
  output logic [FLOW_ID_W-1:0]   timeout_req_flowid,
  input  logic                   timeout_req_rdy,
  input  logic [FLOW_ID_W-1:0]   flag_rd_flowid,
  output logic                   flag_rd_timeout_pending,
  output logic [TIMESTAMP_W-1:0] curr_time
);

  localparam logic [TIMESTAMP_W-1:0] TIMEOUT_TICKS = TIMESTAMP_W'(RT_TIMEOUT);

  typedef enum logic {
    SCAN = 1'b0,
    REQ  = 1'b1
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [FLOW_ID_W-1:0]   scan_idx;
  logic [FLOW_ID_W-1:0]   scan_idx_next;
  logic [FLOW_ID_W-1:0]   req_flowid;
  logic [FLOW_ID_W-1:0]   req_flowid_next;
  logic [NUM_FLOWS-1:0]   timer_armed;
  logic [NUM_FLOWS-1:0]   timeout_pending;
  logic [TIMESTAMP_W-1:0] timestamp [NUM_FLOWS];
  logic [TIMESTAMP_W-1:0] elapsed;
  logic                   scan_expired;
  logic                   scan_write_hit;
  logic                   fire;

  // Expiry test for the entry under the scan pointer; the modular subtraction
  // keeps the elapsed time correct across wrap of the time counter.
  always_comb begin
    elapsed        = curr_time - timestamp[scan_idx];
    scan_expired   = timer_armed[scan_idx] && !timeout_pending[scan_idx] &&
                     (elapsed >= TIMEOUT_TICKS);
    scan_write_hit = set_timer_val && (set_timer_flowid == scan_idx);
  end

  // Next-state logic: fire on an expired entry unless a same-cycle timer write
  // targets it (the write wins), otherwise keep walking; in REQ wait for rdy.
  always_comb begin
    state_next      = state;
    scan_idx_next   = scan_idx;
    req_flowid_next = req_flowid;
    fire            = 1'b0;
    case (state)
      SCAN: begin
        if (scan_expired && !scan_write_hit) begin
          fire            = 1'b1;
          req_flowid_next = scan_idx;
          state_next      = REQ;
        end else begin
          scan_idx_next = scan_idx + 1'b1;
        end
      end
      REQ: begin
        if (timeout_req_rdy) begin
          state_next    = SCAN;
          scan_idx_next = scan_idx + 1'b1;
        end
      end
      default: state_next = SCAN;
    endcase
  end

  // State, scan pointer and latched request flow id.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= SCAN;
      scan_idx   <= '0;
      req_flowid <= '0;
    end else begin
      state      <= state_next;
      scan_idx   <= scan_idx_next;
      req_flowid <= req_flowid_next;
    end
  end

  // Per-flow timer and pending flags; writes from the TX engine, clears from
  // the consumer and the fire's own updates all land on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_armed     <= '0;
      timeout_pending <= '0;
      for (int i = 0; i < NUM_FLOWS; i++) begin
        timestamp[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_FLOWS; i++) begin
        if (set_timer_val && (set_timer_flowid == FLOW_ID_W'(i))) begin
          timer_armed[i] <= set_timer_arm;
          if (set_timer_arm) begin
            timestamp[i] <= curr_time;
          end
        end else if (fire && (scan_idx == FLOW_ID_W'(i))) begin
          timer_armed[i] <= 1'b0;
        end
        if (fire && (scan_idx == FLOW_ID_W'(i))) begin
          timeout_pending[i] <= 1'b1;
        end else if (timeout_clr_val && (timeout_clr_flowid == FLOW_ID_W'(i))) begin
          timeout_pending[i] <= 1'b0;
        end
      end
    end
  end

  // Free-running time base, wraps naturally at its width.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      curr_time <= '0;
    end else begin
      curr_time <= curr_time + 1'b1;
    end
  end

  assign timeout_req_val         = (state == REQ);
  assign timeout_req_flowid      = req_flowid;
  assign flag_rd_timeout_pending = timeout_pending[flag_rd_flowid];

endmodule

// File: tb/tb_tx_rt_timer_scanner.sv
// Directed bench for tx_rt_timer_scanner. Inputs change and outputs are
// sampled on the falling clock edge; every accepted request is logged.
// After each reset the scan pointer equals curr_time mod 8 until the first
// request, which makes fire times exactly predictable.
module tb_tx_rt_timer_scanner;

  localparam int NUM_FLOWS   = 8;
  localparam int FLOW_ID_W   = 3;
  localparam int TIMESTAMP_W = 16;
  localparam int RT_TIMEOUT  = 1000;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   set_timer_val = 1'b0;
  logic [FLOW_ID_W-1:0]   set_timer_flowid = '0;
  logic                   set_timer_arm = 1'b0;
  logic                   timeout_clr_val = 1'b0;
  logic [FLOW_ID_W-1:0]   timeout_clr_flowid = '0;
  logic                   timeout_req_val;
  logic [FLOW_ID_W-1:0]   timeout_req_flowid;
  logic                   timeout_req_rdy = 1'b1;
  logic [FLOW_ID_W-1:0]   flag_rd_flowid = '0;
  logic                   flag_rd_timeout_pending;
  logic [TIMESTAMP_W-1:0] curr_time;

  int check_count = 0;
  int error_count = 0;
  logic [FLOW_ID_W-1:0] hs_log [$];

  tx_rt_timer_scanner #(
    .NUM_FLOWS  (NUM_FLOWS),
    .FLOW_ID_W  (FLOW_ID_W),
    .TIMESTAMP_W(TIMESTAMP_W),
    .RT_TIMEOUT (RT_TIMEOUT)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .set_timer_val          (set_timer_val),
    .set_timer_flowid       (set_timer_flowid),
    .set_timer_arm          (set_timer_arm),
    .timeout_clr_val        (timeout_clr_val),
    .timeout_clr_flowid     (timeout_clr_flowid),
    .timeout_req_val        (timeout_req_val),
    .timeout_req_flowid     (timeout_req_flowid),
    .timeout_req_rdy        (timeout_req_rdy),
    .flag_rd_flowid         (flag_rd_flowid),
    .flag_rd_timeout_pending(flag_rd_timeout_pending),
    .curr_time              (curr_time)
  );

  // 20-unit clock period.
  always #10 clk = ~clk;

  // Record the flow id of every completed handshake.
  always @(posedge clk) begin
    if (!rst && timeout_req_val && timeout_req_rdy) begin
      hs_log.push_back(timeout_req_flowid);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input int flow, input logic arm);
    set_timer_val    = 1'b1;
    set_timer_flowid = FLOW_ID_W'(flow);
    set_timer_arm    = arm;
    tick();
    set_timer_val    = 1'b0;
    set_timer_arm    = 1'b0;
  endtask

  task automatic clearPending(input int flow);
    timeout_clr_val    = 1'b1;
    timeout_clr_flowid = FLOW_ID_W'(flow);
    tick();
    timeout_clr_val    = 1'b0;
  endtask

  task automatic waitTime(input logic [TIMESTAMP_W-1:0] target);
    int n = 0;
    while (curr_time !== target && n < 70000) begin
      tick();
      n++;
    end
    checkOutput("wait_time", 32'(curr_time), 32'(target));
  endtask

  task automatic waitVal(input string tag, input int max_cycles,
                         output logic [TIMESTAMP_W-1:0] seen_time);
    logic found;
    found = 1'b0;
    for (int i = 0; i <= max_cycles && !found; i++) begin
      if (timeout_req_val) found = 1'b1;
      else if (i < max_cycles) tick();
    end
    checkOutput({tag, "_seen"}, 32'(found), 32'd1);
    seen_time = curr_time;
  endtask

  task automatic checkAllFlags(input string tag, input logic expected);
    for (int i = 0; i < NUM_FLOWS; i++) begin
      flag_rd_flowid = FLOW_ID_W'(i);
      #1;
      checkOutput($sformatf("%s%0d", tag, i), 32'(flag_rd_timeout_pending), 32'(expected));
    end
  endtask

  initial begin
    logic [TIMESTAMP_W-1:0] t;
    int high_count;

    // Reset state
    tick();
    tick();
    checkOutput("rst_val", 32'(timeout_req_val), 32'd0);
    checkOutput("rst_flowid", 32'(timeout_req_flowid), 32'd0);
    checkOutput("rst_time", 32'(curr_time), 32'd0);
    checkAllFlags("rst_flag", 1'b0);
    tick();
    rst = 1'b0;

    // Flow 2 armed at 5: scanned at 1010 (1010 % 8 == 2), val seen at 1011
    waitTime(16'd5);
    applyStimulus(2, 1'b1);
    waitVal("bp1", 1100, t);
    checkOutput("bp1_time", 32'(t), 32'd1011);
    checkOutput("bp1_flowid", 32'(timeout_req_flowid), 32'd2);
    tick();
    checkOutput("bp1_val_drop", 32'(timeout_req_val), 32'd0);
    flag_rd_flowid = 3'd2;
    #1;
    checkOutput("bp1_pending", 32'(flag_rd_timeout_pending), 32'd1);
    checkOutput("bp1_hs_count", 32'(hs_log.size()), 32'd1);
    tick();

    // Backpressure: clear and re-arm flow 2, hold rdy low for 20 cycles
    timeout_req_rdy    = 1'b0;
    timeout_clr_val    = 1'b1;
    timeout_clr_flowid = 3'd2;
    applyStimulus(2, 1'b1);
    timeout_clr_val    = 1'b0;
    waitVal("bp2", 1100, t);
    for (int i = 0; i < 20; i++) begin
      tick();
      checkOutput("bp2_hold_val", 32'(timeout_req_val), 32'd1);
      checkOutput("bp2_hold_flowid", 32'(timeout_req_flowid), 32'd2);
    end
    timeout_req_rdy = 1'b1;
    tick();
    checkOutput("bp2_val_drop", 32'(timeout_req_val), 32'd0);
    checkOutput("bp2_hs_count", 32'(hs_log.size()), 32'd2);

    // Disarm flow 4 after ~500 cycles: nothing for 3000 cycles
    applyStimulus(4, 1'b1);
    repeat (500) tick();
    applyStimulus(4, 1'b0);
    high_count = 0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (timeout_req_val) high_count++;
    end
    checkOutput("disarm_no_req", 32'(high_count), 32'd0);

    // Contention: flow k armed at 8+k, all expire while flow 0 is stalled
    rst = 1'b1;
    tick();
    rst = 1'b0;
    hs_log.delete();
    timeout_req_rdy = 1'b0;
    waitTime(16'd8);
    for (int k = 0; k < NUM_FLOWS; k++) applyStimulus(k, 1'b1);
    waitVal("cont", 1100, t);
    checkOutput("cont_first_time", 32'(t), 32'd1009);
    checkOutput("cont_first_flowid", 32'(timeout_req_flowid), 32'd0);
    repeat (20) tick();
    timeout_req_rdy = 1'b1;
    for (int i = 0; i < 40 && hs_log.size() < NUM_FLOWS; i++) tick();
    checkOutput("cont_hs_count", 32'(hs_log.size()), 32'd8);
    for (int k = 0; k < NUM_FLOWS; k++) begin
      checkOutput($sformatf("cont_order%0d", k),
                  (k < hs_log.size()) ? 32'(hs_log[k]) : 32'hFFFF_FFFF, 32'(k));
    end
    checkAllFlags("cont_flag", 1'b1);

    // Reset while a request for flow 5 is held
    timeout_req_rdy    = 1'b0;
    timeout_clr_val    = 1'b1;
    timeout_clr_flowid = 3'd5;
    applyStimulus(5, 1'b1);
    timeout_clr_val    = 1'b0;
    waitVal("rstreq", 1100, t);
    checkOutput("rstreq_flowid", 32'(timeout_req_flowid), 32'd5);
    rst = 1'b1;
    #1;
    checkOutput("rstreq_val", 32'(timeout_req_val), 32'd0);
    checkOutput("rstreq_flowid0", 32'(timeout_req_flowid), 32'd0);
    checkOutput("rstreq_time", 32'(curr_time), 32'd0);
    checkAllFlags("rstreq_flag", 1'b0);
    tick();
    rst = 1'b0;
    hs_log.delete();
    timeout_req_rdy = 1'b1;

    // Write wins: flow 1 armed at 9, re-armed exactly when scanned at 1009
    waitTime(16'd9);
    applyStimulus(1, 1'b1);
    waitTime(16'd1009);
    applyStimulus(1, 1'b1);
    checkOutput("ww_no_fire", 32'(timeout_req_val), 32'd0);
    waitVal("ww", 1100, t);
    checkOutput("ww_time", 32'(t), 32'd2010);
    checkOutput("ww_flowid", 32'(timeout_req_flowid), 32'd1);
    tick();

    // Pending suppression and clear on flow 3
    applyStimulus(3, 1'b1);
    waitVal("sup1", 1100, t);
    checkOutput("sup1_flowid", 32'(timeout_req_flowid), 32'd3);
    tick();
    applyStimulus(3, 1'b1);
    high_count = 0;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (timeout_req_val) high_count++;
    end
    checkOutput("sup_no_req", 32'(high_count), 32'd0);
    clearPending(3);
    waitVal("sup_clr", NUM_FLOWS + 1, t);
    checkOutput("sup_clr_flowid", 32'(timeout_req_flowid), 32'd3);
    tick();

    // Wrap-around: armed at 65000, expiry lands at 464 after the wrap
    waitTime(16'd65000);
    applyStimulus(0, 1'b1);
    waitVal("wrap", 1100, t);
    checkOutput("wrap_time_window", 32'(t >= 16'd465 && t <= 16'd473), 32'd1);
    checkOutput("wrap_flowid", 32'(timeout_req_flowid), 32'd0);
    tick();

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
